// File: rtl/uart_wb_host.sv
// rtl/uart_wb_host.sv - Wishbone master that initialises and services a 16550-style UART
// Ports:
//   clock, wb_rst_n                    clock and async active-low reset
//   wb_addr_o/sel_o/dat_o/we_o/stb_o/cyc_o, wb_dat_i, wb_ack_i   Wishbone master port
//   tx_data/tx_valid/tx_ready          byte stream into the THR
//   rx_data/rx_valid/rx_ready          one-entry holding register fed from the RBR
//   init_done, bus_err                 status (bus_err is sticky)
module uart_wb_host #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'h07,
  parameter int          POLL_CYCLES = 64,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       wb_rst_n,
  output logic [3:0] wb_addr_o,
  output logic [3:0] wb_sel_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done,
  output logic       bus_err
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [3:0] S_INIT_LCR_DLAB = 4'd0;
  localparam logic [3:0] S_INIT_DLL      = 4'd1;
  localparam logic [3:0] S_INIT_DLM      = 4'd2;
  localparam logic [3:0] S_INIT_LCR      = 4'd3;
  localparam logic [3:0] S_INIT_FCR      = 4'd4;
  localparam logic [3:0] S_IDLE          = 4'd5;
  localparam logic [3:0] S_POLL_LSR      = 4'd6;
  localparam logic [3:0] S_RD_RBR        = 4'd7;
  localparam logic [3:0] S_WR_THR        = 4'd8;

  logic [3:0]    state_q, state_d;
  logic          stb_q, stb_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    dat_q, dat_d;
  logic          we_q, we_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          tx_ready_q, tx_ready_d;
  logic          init_done_q, init_done_d;
  logic          bus_err_q, bus_err_d;

  // Address/direction/data each bus state presents when its strobe rises.
  logic [3:0] acc_addr;
  logic [7:0] acc_dat;
  logic       acc_we;

  always_comb begin
    acc_addr = 4'd0;
    acc_dat  = 8'h00;
    acc_we   = 1'b0;
    case (state_q)
      S_INIT_LCR_DLAB: begin acc_addr = 4'd3; acc_dat = LCR_VAL | 8'h80; acc_we = 1'b1; end
      S_INIT_DLL:      begin acc_addr = 4'd0; acc_dat = DIVISOR[7:0];    acc_we = 1'b1; end
      S_INIT_DLM:      begin acc_addr = 4'd1; acc_dat = DIVISOR[15:8];   acc_we = 1'b1; end
      S_INIT_LCR:      begin acc_addr = 4'd3; acc_dat = LCR_VAL;         acc_we = 1'b1; end
      S_INIT_FCR:      begin acc_addr = 4'd2; acc_dat = FCR_VAL;         acc_we = 1'b1; end
      S_POLL_LSR:      begin acc_addr = 4'd5; end
      S_WR_THR:        begin acc_addr = 4'd0; acc_dat = tx_data;         acc_we = 1'b1; end
      default:         begin acc_addr = 4'd0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    tmo_d       = tmo_q;
    poll_d      = poll_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    tx_ready_d  = 1'b0;
    init_done_d = init_done_q;
    bus_err_d   = bus_err_q;

    // Consumer handshake; an RBR ack in the same cycle overrides below.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (state_q == S_IDLE) begin
      if (tx_valid || poll_q == '0) begin
        state_d = S_POLL_LSR;
        poll_d  = PW'(POLL_CYCLES);
      end else begin
        poll_d = poll_q - 1'b1;
      end
    end else if (!stb_q) begin
      // Strobe rises one cycle after entering a bus state, which also gives
      // the mandatory idle cycle between back-to-back accesses.
      stb_d  = 1'b1;
      tmo_d  = '0;
      addr_d = acc_addr;
      dat_d  = acc_dat;
      we_d   = acc_we;
    end else if (wb_ack_i) begin
      stb_d  = 1'b0;
      addr_d = 4'd0;
      dat_d  = 8'h00;
      we_d   = 1'b0;
      case (state_q)
        S_INIT_LCR_DLAB: state_d = S_INIT_DLL;
        S_INIT_DLL:      state_d = S_INIT_DLM;
        S_INIT_DLM:      state_d = S_INIT_LCR;
        S_INIT_LCR:      state_d = S_INIT_FCR;
        S_INIT_FCR: begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
        S_POLL_LSR: begin
          if (wb_dat_i[0] && (!rx_valid_q || rx_ready)) state_d = S_RD_RBR;
          else if (wb_dat_i[5] && tx_valid)             state_d = S_WR_THR;
          else                                          state_d = S_IDLE;
        end
        S_RD_RBR: begin
          rx_data_d  = wb_dat_i;
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
        S_WR_THR: begin
          tx_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
      // Abandon the access; a stalled init still reports done so the
      // host can proceed to service traffic.
      stb_d     = 1'b0;
      addr_d    = 4'd0;
      dat_d     = 8'h00;
      we_d      = 1'b0;
      bus_err_d = 1'b1;
      state_d   = S_IDLE;
      if (state_q <= S_INIT_FCR) init_done_d = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= S_INIT_LCR_DLAB;
      stb_q       <= 1'b0;
      addr_q      <= 4'd0;
      dat_q       <= 8'h00;
      we_q        <= 1'b0;
      tmo_q       <= '0;
      poll_q      <= PW'(POLL_CYCLES);
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      tmo_q       <= tmo_d;
      poll_q      <= poll_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
      init_done_q <= init_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign wb_addr_o = addr_q;
  assign wb_sel_o  = {3'b000, stb_q};
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign init_done = init_done_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_uart_wb_host.sv
// tb/tb_uart_wb_host.sv - scoreboard bench for uart_wb_host against a behavioural UART slave
`timescale 1ns/1ps
module tb_uart_wb_host;

  localparam logic [15:0] TB_DIV = 16'd27;
  localparam logic [7:0]  TB_LCR = 8'h03;
  localparam logic [7:0]  TB_FCR = 8'h07;

  logic       clock = 1'b0;
  logic       wb_rst_n;
  logic [3:0] wb_addr_o;
  logic [3:0] wb_sel_o;
  logic [7:0] wb_dat_o;
  logic       wb_we_o, wb_stb_o, wb_cyc_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       init_done, bus_err;

  uart_wb_host dut (
    .clock(clock), .wb_rst_n(wb_rst_n),
    .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave-side UART model and scoreboard queues
  logic [7:0]  rxq[$];
  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rx[$];
  logic        thre = 1'b1;
  logic        no_ack = 1'b0;
  logic        rand_delay = 1'b0;
  logic        rand_rx = 1'b0;
  logic        rx_ready_dir = 1'b0;
  int          ack_delay = 1;

  int wr_cnt = 0, thr_cnt = 0, rbr_cnt = 0, lsr_cnt = 0, rx_cnt = 0, tx_ready_cnt = 0;
  int tx_sent = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  // Behavioural slave: acks after a wait count, LSR reflects THRE and RX queue state.
  initial begin
    int wcnt, cur_wait;
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    wcnt = 0;
    cur_wait = 1;
    forever begin
      @(posedge clock);
      #1;
      if (wb_ack_i || !(wb_cyc_o && wb_stb_o)) begin
        wb_ack_i = 1'b0;
        wcnt = 0;
        cur_wait = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
      end else if (no_ack) begin
        wcnt = 0;
      end else if (wcnt < cur_wait) begin
        wcnt++;
      end else begin
        wb_ack_i = 1'b1;
        wb_dat_i = 8'h00;
        if (!wb_we_o) begin
          if (wb_addr_o == 4'd5)
            wb_dat_i = {1'b0, thre, thre, 4'b0000, rxq.size() != 0};
          else if (wb_addr_o == 4'd0 && rxq.size() != 0)
            wb_dat_i = rxq.pop_front();
        end
      end
    end
  end

  // Consumer ready driver: random backpressure or directed level.
  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      rx_ready = rand_rx ? 1'($urandom_range(0, 1)) : rx_ready_dir;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer.
  initial begin
    logic [11:0] ew;
    logic [8:0]  er;
    forever begin
      @(negedge clock);
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        check("wb_sel", {28'd0, wb_sel_o}, 32'd1);
        if (wb_we_o) begin
          wr_cnt++;
          if (wb_addr_o == 4'd0) thr_cnt++;
          ew = (exp_wr.size() != 0) ? exp_wr.pop_front() : 12'hFFF;
          check("bus_write", {20'd0, wb_addr_o, wb_dat_o}, {20'd0, ew});
        end else begin
          if (wb_addr_o == 4'd0) rbr_cnt++;
          if (wb_addr_o == 4'd5) lsr_cnt++;
        end
      end
      if (rx_valid && rx_ready) begin
        rx_cnt++;
        er = (exp_rx.size() != 0) ? {1'b0, exp_rx.pop_front()} : 9'h100;
        check("rx_data", {24'd0, rx_data}, {23'd0, er});
      end
      if (tx_ready) tx_ready_cnt++;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_init();
    exp_wr.push_back({4'd3, TB_LCR | 8'h80});
    exp_wr.push_back({4'd0, 8'(TB_DIV % 256)});
    exp_wr.push_back({4'd1, 8'(TB_DIV / 256)});
    exp_wr.push_back({4'd3, TB_LCR});
    exp_wr.push_back({4'd2, TB_FCR});
  endtask

  task automatic init_check();
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (wb_stb_o && wb_ack_i && wb_we_o && wb_addr_o == 4'd2) found = 1'b1;
    end
    check("init_fcr_ack_seen", {31'd0, found}, 32'd1);
    check("init_done_before_last_ack", {31'd0, init_done}, 32'd0);
    tick();
    check("init_done_after_last_ack", {31'd0, init_done}, 32'd1);
    check("init_writes_consumed", exp_wr.size(), 32'd0);
  endtask

  task automatic wait_tx_ready(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      tick();
      if (tx_ready) got = 1'b1;
    end
    check(name, {31'd0, got}, 32'd1);
    if (got) tx_sent++;
    tx_valid = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] b, input string name);
    exp_wr.push_back({4'd0, b});
    tx_data  = b;
    tx_valid = 1'b1;
    wait_tx_ready(name);
  endtask

  task automatic wait_bus_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      if (!wb_cyc_o) ok = 1'b1;
    end
    check("bus_idle_reached", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int base_a, base_b, cnt;
    bit ok;
    logic [7:0] b;
    wb_rst_n = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    repeat (3) tick();
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    check("rst_addr_dat_we", {19'd0, wb_addr_o, wb_dat_o, wb_we_o}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx", {23'd0, rx_valid, rx_data}, 32'd0);
    check("rst_status", {30'd0, init_done, bus_err}, 32'd0);

    push_init();
    wb_rst_n = 1'b1;
    init_check();
    check("bus_err_after_init", {31'd0, bus_err}, 32'd0);

    // TX with THRE set, then THRE clear holds the next byte back.
    thre = 1'b1;
    send_tx(8'hA5, "tx_a5_accept");
    tick();
    check("tx_ready_single_cycle", {31'd0, tx_ready}, 32'd0);
    thre = 1'b0;
    base_a = thr_cnt;
    base_b = lsr_cnt;
    exp_wr.push_back({4'd0, 8'h5A});
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    repeat (150) tick();
    check("no_thr_write_thre0", thr_cnt, base_a);
    check("polls_while_thre0", {31'd0, lsr_cnt > base_b + 2}, 32'd1);
    thre = 1'b1;
    wait_tx_ready("tx_5a_after_thre");

    // RX has priority over a pending TX byte.
    rx_ready_dir = 1'b1;
    wait_bus_idle();
    base_a = rx_cnt;
    rxq.push_back(8'h3C);
    exp_rx.push_back(8'h3C);
    send_tx(8'hC3, "tx_c3_after_rx");
    check("rx_before_tx", rx_cnt, base_a + 1);

    // Backpressure: a held rx byte blocks further RBR reads.
    rx_ready_dir = 1'b0;
    repeat (3) tick();
    wait_bus_idle();
    rxq.push_back(8'h11);
    exp_rx.push_back(8'h11);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (rx_valid) ok = 1'b1;
    end
    check("rx_valid_seen", {31'd0, ok}, 32'd1);
    rxq.push_back(8'h22);
    exp_rx.push_back(8'h22);
    base_a = rbr_cnt;
    base_b = lsr_cnt;
    repeat (300) tick();
    check("no_rbr_while_full", rbr_cnt, base_a);
    check("polls_while_full", {31'd0, lsr_cnt >= base_b + 3}, 32'd1);
    check("rx_held", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h11});
    rx_ready_dir = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      if (exp_rx.size() == 0 && !rx_valid) ok = 1'b1;
    end
    check("rx_drained", {31'd0, ok}, 32'd1);
    check("one_rbr_after_release", rbr_cnt, base_a + 1);

    // Ack timeout on an LSR poll.
    wait_bus_idle();
    no_ack = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (wb_stb_o && wb_addr_o == 4'd5) ok = 1'b1;
    end
    check("timeout_poll_started", {31'd0, ok}, 32'd1);
    cnt = 0;
    while (wb_stb_o && cnt < 400) begin
      cnt++;
      tick();
    end
    check("timeout_stb_cycles", cnt, 32'd255);
    check("bus_err_set", {31'd0, bus_err}, 32'd1);
    no_ack = 1'b0;
    base_a = lsr_cnt;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (lsr_cnt > base_a) ok = 1'b1;
    end
    check("poll_retried", {31'd0, ok}, 32'd1);
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset in the middle of a THR write.
    ack_delay = 10;
    wait_bus_idle();
    tx_data = 8'h77;
    tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (wb_stb_o && wb_we_o && wb_addr_o == 4'd0) ok = 1'b1;
    end
    check("thr_write_started", {31'd0, ok}, 32'd1);
    wb_rst_n = 1'b0;
    #1;
    check("mid_rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("mid_rst_status", {30'd0, init_done, bus_err}, 32'd0);
    tx_valid = 1'b0;
    exp_wr.delete();
    push_init();
    ack_delay = 1;
    repeat (2) tick();
    wb_rst_n = 1'b1;
    init_check();

    // Randomised traffic with random ack latency and consumer backpressure.
    rand_delay = 1'b1;
    rand_rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      int r;
      r = int'($urandom_range(0, 3));
      if (r % 2 == 1) begin
        b = 8'($urandom);
        rxq.push_back(b);
        exp_rx.push_back(b);
      end
      if (r >= 2) send_tx(8'($urandom), "tx_random_accept");
      else repeat ($urandom_range(1, 20)) tick();
    end
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      tick();
      if (exp_rx.size() == 0 && rxq.size() == 0 && !rx_valid) ok = 1'b1;
    end
    check("random_rx_drained", {31'd0, ok}, 32'd1);
    check("write_queue_empty", exp_wr.size(), 32'd0);
    check("tx_ready_count", tx_ready_cnt, tx_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
